// File: rtl/bp_pkg.sv
// Shared types, constants and counter arithmetic for the two-level branch predictor.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b11;
    localparam logic [1:0] ST  = 2'b10;

    localparam logic [1:0] BP_LOCAL  = 2'b00;
    localparam logic [1:0] BP_GLOBAL = 2'b01;
    localparam logic [1:0] BP_GSHARE = 2'b10;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bpState_e;

    // Gray-like encoding keeps the prediction in bit 1 for both taken states.
    function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            case (ctr)
                SNT:     nxt = WNT;
                WNT:     nxt = WT;
                WT:      nxt = ST;
                default: nxt = ST;
            endcase
        end else begin
            case (ctr)
                ST:      nxt = WT;
                WT:      nxt = WNT;
                WNT:     nxt = SNT;
                default: nxt = SNT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational next-state for one 2-bit saturating direction counter.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] next_o
);

    assign next_o = sat_next(ctr_i, taken_i);

endmodule

// File: rtl/branch_predict_tl.sv
// Two-level direction predictor (local / global / gshare), PHT cleared by a sweep FSM.
// Optional BP_STATS_EN adds branch and mispredict counters.
module branch_predict_tl
    import bp_pkg::*;
#(
    parameter int         BHT_DEPTH = 10,
    parameter int         PHT_DEPTH = 6,
    parameter logic [1:0] PHT_INIT  = ST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        flushD,
    input  logic        stallD,
    input  logic [31:0] pcF,
    input  logic [31:0] pcM,
    input  logic        branchD,
    input  logic        branchM,
    input  logic        actual_takeM,
    input  logic        pred_takeM,
    output logic        pred_takeD,
    output logic        init_done
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int BHT_N = 2 ** BHT_DEPTH;
    localparam int PHT_N = 2 ** PHT_DEPTH;
    localparam int PTR_W = (BHT_DEPTH > PHT_DEPTH) ? BHT_DEPTH : PHT_DEPTH;

    logic [PHT_DEPTH-1:0] bht [BHT_N];
    logic [1:0]           pht [PHT_N];

    bpState_e             state_q, state_d;
    logic [PTR_W-1:0]     sweepPtr_q, sweepPtr_d;
    logic [PHT_DEPTH-1:0] ghr_q, ghr_d;
    logic                 predD_q, predD_d;

    logic [BHT_DEPTH-1:0] bhtIdxF, bhtIdxM;
    logic [PHT_DEPTH-1:0] idxF, idxM, histM;
    logic [1:0]           ctrM, ctrNextM;
    logic                 predF, train, sweepInPht, sweepInBht;
    logic                 unusedBits;

    assign bhtIdxF = pcF[BHT_DEPTH+1:2];
    assign bhtIdxM = pcM[BHT_DEPTH+1:2];
    assign histM   = bht[bhtIdxM];
    assign unusedBits = ^{pcF, pcM, pred_takeM};

    // Mode 11 falls into the default arm and therefore indexes as gshare.
    always_comb begin
        idxF = pcF[PHT_DEPTH+1:2] ^ ghr_q;
        idxM = pcM[PHT_DEPTH+1:2] ^ ghr_q;
        case (mode)
            BP_LOCAL: begin
                idxF = bht[bhtIdxF];
                idxM = histM;
            end
            BP_GLOBAL: begin
                idxF = ghr_q;
                idxM = ghr_q;
            end
            default: ;
        endcase
    end

    assign ctrM  = pht[idxM];
    assign predF = (state_q == BP_RUN) && pht[idxF][1];
    assign train = (state_q == BP_RUN) && branchM;

    bp_sat_ctr u_satCtr (
        .ctr_i   (ctrM),
        .taken_i (actual_takeM),
        .next_o  (ctrNextM)
    );

    always_comb begin
        state_d    = state_q;
        sweepPtr_d = sweepPtr_q;
        case (state_q)
            BP_INIT: begin
                sweepPtr_d = sweepPtr_q + 1'b1;
                if (sweepPtr_q == '1) state_d = BP_RUN;
            end
            default: ;
        endcase
        ghr_d   = train ? {ghr_q[PHT_DEPTH-2:0], actual_takeM} : ghr_q;
        predD_d = flushD ? 1'b0 : (stallD ? predD_q : predF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BP_INIT;
            sweepPtr_q <= '0;
            ghr_q      <= '0;
            predD_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweepPtr_q <= sweepPtr_d;
            ghr_q      <= ghr_d;
            predD_q    <= predD_d;
        end
    end

    // The sweep covers the larger table; the smaller one ignores out-of-range pointers.
    assign sweepInPht = ({1'b0, sweepPtr_q} < (PTR_W+1)'(PHT_N));
    assign sweepInBht = ({1'b0, sweepPtr_q} < (PTR_W+1)'(BHT_N));

    always_ff @(posedge clk) begin
        if (state_q == BP_INIT) begin
            if (sweepInPht) pht[sweepPtr_q[PHT_DEPTH-1:0]] <= PHT_INIT;
            if (sweepInBht) bht[sweepPtr_q[BHT_DEPTH-1:0]] <= '0;
        end else if (branchM) begin
            pht[idxM]    <= ctrNextM;
            bht[bhtIdxM] <= {histM[PHT_DEPTH-2:0], actual_takeM};
        end
    end

    assign pred_takeD = branchD & predD_q;
    assign init_done  = (state_q == BP_RUN);

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (train) begin
            stat_branches <= stat_branches + 32'd1;
            if (pred_takeM != actual_takeM) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule
